// File: rtl/ctrl_pkg.sv
// Shared decode definitions: RV32I opcodes, immediate-format codes and the
// packed control bundle carried through the ID/EX register.
package ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  localparam logic [2:0] IMM_I   = 3'b000;
  localparam logic [2:0] IMM_S   = 3'b001;
  localparam logic [2:0] IMM_B   = 3'b010;
  localparam logic [2:0] IMM_J   = 3'b011;
  localparam logic [2:0] IMM_U   = 3'b100;
  localparam logic [2:0] IMM_ISH = 3'b101;

  typedef struct packed {
    logic [4:0] alu_op;
    logic       rd_en;
    logic       rs1_read;
    logic       rs2_read;
    logic       dm_we;
    logic       dm_re;
    logic       rd_sel;
    logic       alu_a_sel;
    logic       alu_b_sel;
    logic       branch;
    logic       jump;
    logic [2:0] imm_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Bus between fetch, the decode stage and execute. master = upstream/EX side
// driving requests and ready, slave = the decode stage itself.
interface ctrl_decode_stage_if #(parameter int XLEN = 32);

  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic            stall;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [4:0]      out_alu_op;
  logic            out_rd_en;
  logic            out_rs1_read;
  logic            out_rs2_read;
  logic            out_dm_we;
  logic            out_dm_re;
  logic            out_rd_sel;
  logic            out_alu_a_sel;
  logic            out_alu_b_sel;
  logic            out_branch;
  logic            out_jump;
  logic [2:0]      out_imm_sel;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [2:0]      out_func3;
  logic [XLEN-1:0] out_pc;
  logic            out_illegal;

  modport master (
    output in_valid, in_instr, in_pc, stall, flush, out_ready,
    input  in_ready, out_valid, out_alu_op, out_rd_en, out_rs1_read, out_rs2_read,
           out_dm_we, out_dm_re, out_rd_sel, out_alu_a_sel, out_alu_b_sel,
           out_branch, out_jump, out_imm_sel, out_rd, out_rs1, out_rs2,
           out_func3, out_pc, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, in_pc, stall, flush, out_ready,
    output in_ready, out_valid, out_alu_op, out_rd_en, out_rs1_read, out_rs2_read,
           out_dm_we, out_dm_re, out_rd_sel, out_alu_a_sel, out_alu_b_sel,
           out_branch, out_jump, out_imm_sel, out_rd, out_rs1, out_rs2,
           out_func3, out_pc, out_illegal
  );

endinterface

// File: rtl/ctrl_decode_comb.sv
// Purely combinational RV32I control decode: instruction word to control bundle,
// register fields and illegal flag. CTRL_MEXT_EN enables M-extension decode.
module ctrl_decode_comb
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        illegal,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  func3
);

  logic [6:0] opcode;
  logic [6:0] func7;

  assign opcode = instr[6:0];
  assign func7  = instr[31:25];
  assign rd     = instr[11:7];
  assign func3  = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // Anything not matched keeps the all-zero bundle and raises illegal.
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        if (func7 == F7_BASE || func7 == F7_ALT) begin
          ctrl.alu_op   = {1'b0, func7[5], func3};
          ctrl.rd_en    = 1'b1;
          ctrl.rs1_read = 1'b1;
          ctrl.rs2_read = 1'b1;
`ifdef CTRL_MEXT_EN
        end else if (func7 == F7_MEXT) begin
          ctrl.alu_op   = {1'b1, 1'b0, func3};
          ctrl.rd_en    = 1'b1;
          ctrl.rs1_read = 1'b1;
          ctrl.rs2_read = 1'b1;
`endif
        end else begin
          illegal = 1'b1;
        end
      end
      OP_IALU: begin
        ctrl.alu_op    = {1'b0, func7[5], func3};
        ctrl.rd_en     = 1'b1;
        ctrl.rs1_read  = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.imm_sel   = (func3 == 3'b101) ? IMM_ISH : IMM_I;
      end
      OP_LOAD: begin
        ctrl.rd_en     = 1'b1;
        ctrl.rs1_read  = 1'b1;
        ctrl.dm_re     = 1'b1;
        ctrl.rd_sel    = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.imm_sel   = IMM_I;
      end
      OP_STORE: begin
        ctrl.rs1_read  = 1'b1;
        ctrl.dm_we     = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.imm_sel   = IMM_S;
      end
      OP_BRANCH: begin
        ctrl.rs1_read  = 1'b1;
        ctrl.rs2_read  = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.imm_sel   = IMM_B;
      end
      OP_JAL: begin
        ctrl.rd_en     = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.imm_sel   = IMM_J;
      end
      OP_JALR: begin
        ctrl.rd_en     = 1'b1;
        ctrl.rs1_read  = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.imm_sel   = IMM_I;
      end
      OP_LUI: begin
        ctrl.rd_en   = 1'b1;
        ctrl.imm_sel = IMM_U;
      end
      OP_AUIPC: begin
        ctrl.rd_en     = 1'b1;
        ctrl.alu_a_sel = 1'b1;
        ctrl.alu_b_sel = 1'b1;
        ctrl.imm_sel   = IMM_U;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode stage (ID/EX register) with handshake, stall/flush,
// load-use bubble insertion and a saturating bubble counter.
module ctrl_decode_stage
  import ctrl_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  ctrl_decode_stage_if.slave bus,
  output logic [PERF_W-1:0] bubble_cnt
);

  ctrl_t           dec_ctrl;
  logic            dec_illegal;
  logic [4:0]      dec_rd, dec_rs1, dec_rs2;
  logic [2:0]      dec_func3;

  ctrl_t           ctrl_q, ctrl_out;
  logic            valid_q, illegal_q;
  logic [4:0]      rd_q, rs1_q, rs2_q;
  logic [2:0]      func3_q;
  logic [XLEN-1:0] pc_q;
  logic            hazard, in_ready;

  ctrl_decode_comb u_decode (
    .instr   (bus.in_instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal),
    .rd      (dec_rd),
    .rs1     (dec_rs1),
    .rs2     (dec_rs2),
    .func3   (dec_func3)
  );

  // A load in the register whose destination the incoming instruction reads.
  assign hazard = valid_q && ctrl_q.dm_re && (rd_q != 5'd0) && bus.in_valid &&
                  ((dec_ctrl.rs1_read && (dec_rs1 == rd_q)) ||
                   (dec_ctrl.rs2_read && (dec_rs2 == rd_q)));

  assign in_ready = bus.flush ||
                    (!bus.stall && !hazard && (!valid_q || bus.out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= CTRL_BUBBLE;
      illegal_q  <= 1'b0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      func3_q    <= '0;
      pc_q       <= '0;
      bubble_cnt <= '0;
    end else if (bus.flush) begin
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      if (hazard && bus.out_ready) begin
        valid_q   <= 1'b0;
        ctrl_q    <= CTRL_BUBBLE;
        illegal_q <= 1'b0;
        if (bubble_cnt != {PERF_W{1'b1}})
          bubble_cnt <= bubble_cnt + 1'b1;
      end else if (bus.in_valid && in_ready) begin
        valid_q   <= 1'b1;
        ctrl_q    <= dec_ctrl;
        illegal_q <= dec_illegal;
        rd_q      <= dec_rd;
        rs1_q     <= dec_rs1;
        rs2_q     <= dec_rs2;
        func3_q   <= dec_func3;
        pc_q      <= bus.in_pc;
      end else if (bus.out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Invalid register contents must never leak control bits into EX.
  assign ctrl_out = valid_q ? ctrl_q : CTRL_BUBBLE;

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = valid_q;
  assign bus.out_alu_op    = ctrl_out.alu_op;
  assign bus.out_rd_en     = ctrl_out.rd_en;
  assign bus.out_rs1_read  = ctrl_out.rs1_read;
  assign bus.out_rs2_read  = ctrl_out.rs2_read;
  assign bus.out_dm_we     = ctrl_out.dm_we;
  assign bus.out_dm_re     = ctrl_out.dm_re;
  assign bus.out_rd_sel    = ctrl_out.rd_sel;
  assign bus.out_alu_a_sel = ctrl_out.alu_a_sel;
  assign bus.out_alu_b_sel = ctrl_out.alu_b_sel;
  assign bus.out_branch    = ctrl_out.branch;
  assign bus.out_jump      = ctrl_out.jump;
  assign bus.out_imm_sel   = ctrl_out.imm_sel;
  assign bus.out_illegal   = valid_q & illegal_q;
  assign bus.out_rd        = rd_q;
  assign bus.out_rs1       = rs1_q;
  assign bus.out_rs2       = rs2_q;
  assign bus.out_func3     = func3_q;
  assign bus.out_pc        = pc_q;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Directed bench for ctrl_decode_stage; a second instance with PERF_W = 2
// mirrors the stimulus to exercise counter saturation. Honours CTRL_MEXT_EN.
module tb_ctrl_decode_stage;

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_LW5   = 32'h0000A283;
  localparam logic [31:0] I_USE1  = 32'h00228333;
  localparam logic [31:0] I_USE2  = 32'h00508333;
  localparam logic [31:0] I_LW0   = 32'h0000A003;
  localparam logic [31:0] I_USE0  = 32'h00200333;
  localparam logic [31:0] I_SUB   = 32'h402083B3;
  localparam logic [31:0] I_SRAI  = 32'h4030D213;
  localparam logic [31:0] I_SW    = 32'h0020A423;
  localparam logic [31:0] I_BEQ   = 32'h00208063;
  localparam logic [31:0] I_JAL   = 32'h000000EF;
  localparam logic [31:0] I_LUI   = 32'h123452B7;
  localparam logic [31:0] I_ILL   = 32'h0000007F;
  localparam logic [31:0] I_MUL   = 32'h022081B3;

  logic        clk;
  logic        rst_n;
  logic [15:0] bubble_cnt;
  logic [1:0]  sat_cnt;
  int          checks = 0;
  int          errors = 0;

  ctrl_decode_stage_if #(.XLEN(32)) ifa ();
  ctrl_decode_stage_if #(.XLEN(32)) ifb ();

  assign ifb.in_valid  = ifa.in_valid;
  assign ifb.in_instr  = ifa.in_instr;
  assign ifb.in_pc     = ifa.in_pc;
  assign ifb.stall     = ifa.stall;
  assign ifb.flush     = ifa.flush;
  assign ifb.out_ready = ifa.out_ready;

  ctrl_decode_stage #(.XLEN(32), .PERF_W(16)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifa.slave),
    .bubble_cnt (bubble_cnt)
  );

  ctrl_decode_stage #(.XLEN(32), .PERF_W(2)) u_sat (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (ifb.slave),
    .bubble_cnt (sat_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Control bundle order: alu_op, 10 flags (rd_en rs1_read rs2_read dm_we dm_re
  // rd_sel alu_a_sel alu_b_sel branch jump), imm_sel, illegal.
  task automatic check_ctrl(input string tag, input logic [4:0] alu, input logic [9:0] flags,
                            input logic [2:0] imm, input logic ill);
    logic [18:0] obs;
    obs = {ifa.out_alu_op, ifa.out_rd_en, ifa.out_rs1_read, ifa.out_rs2_read, ifa.out_dm_we,
           ifa.out_dm_re, ifa.out_rd_sel, ifa.out_alu_a_sel, ifa.out_alu_b_sel, ifa.out_branch,
           ifa.out_jump, ifa.out_imm_sel, ifa.out_illegal};
    check_output(tag, 64'(obs), 64'({alu, flags, imm, ill}));
  endtask

  task automatic apply_stimulus(input logic v, input logic [31:0] instr, input logic [31:0] pc);
    ifa.in_valid = v;
    ifa.in_instr = instr;
    ifa.in_pc    = pc;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    ifa.in_valid  = 1'b0;
    ifa.in_instr  = '0;
    ifa.in_pc     = '0;
    ifa.stall     = 1'b0;
    ifa.flush     = 1'b0;
    ifa.out_ready = 1'b1;
    #2;
    check_output("rst_valid", 64'(ifa.out_valid), 64'd0);
    check_ctrl("rst_ctrl", 5'b0, 10'b0, 3'b0, 1'b0);
    check_output("rst_rd", 64'(ifa.out_rd), 64'd0);
    check_output("rst_pc", 64'(ifa.out_pc), 64'd0);
    check_output("rst_cnt", 64'(bubble_cnt), 64'd0);
    check_output("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    #10 rst_n = 1'b1;

    apply_stimulus(1'b1, I_ADD, 32'h0);
    check_output("add_in_ready", 64'(ifa.in_ready), 64'd1);
    tick();
    check_output("add_valid", 64'(ifa.out_valid), 64'd1);
    check_ctrl("add_ctrl", 5'b00000, 10'b1110000000, 3'b000, 1'b0);
    check_output("add_rd", 64'(ifa.out_rd), 64'd3);
    check_output("add_rs1", 64'(ifa.out_rs1), 64'd1);
    check_output("add_rs2", 64'(ifa.out_rs2), 64'd2);

    apply_stimulus(1'b1, I_LW5, 32'h4);
    tick();
    check_ctrl("lw_ctrl", 5'b00000, 10'b1100110100, 3'b000, 1'b0);
    check_output("lw_rd", 64'(ifa.out_rd), 64'd5);
    check_output("lw_pc", 64'(ifa.out_pc), 64'h4);

    apply_stimulus(1'b1, I_USE1, 32'h8);
    check_output("hz_in_ready", 64'(ifa.in_ready), 64'd0);
    tick();
    check_output("bub_valid", 64'(ifa.out_valid), 64'd0);
    check_ctrl("bub_ctrl", 5'b0, 10'b0, 3'b0, 1'b0);
    check_output("bub_cnt", 64'(bubble_cnt), 64'd1);
    tick();
    check_output("use_valid", 64'(ifa.out_valid), 64'd1);
    check_output("use_rd", 64'(ifa.out_rd), 64'd6);
    check_output("use_rs1", 64'(ifa.out_rs1), 64'd5);
    check_output("use_pc", 64'(ifa.out_pc), 64'h8);

    apply_stimulus(1'b1, I_LW0, 32'hC);
    tick();
    apply_stimulus(1'b1, I_USE0, 32'h10);
    check_output("x0_in_ready", 64'(ifa.in_ready), 64'd1);
    tick();
    check_output("x0_valid", 64'(ifa.out_valid), 64'd1);
    check_output("x0_pc", 64'(ifa.out_pc), 64'h10);
    check_output("x0_cnt", 64'(bubble_cnt), 64'd1);

    apply_stimulus(1'b1, I_SUB, 32'h14);
    tick();
    check_ctrl("sub_ctrl", 5'b01000, 10'b1110000000, 3'b000, 1'b0);
    apply_stimulus(1'b1, I_SRAI, 32'h18);
    tick();
    check_ctrl("srai_ctrl", 5'b01101, 10'b1100000100, 3'b101, 1'b0);
    apply_stimulus(1'b1, I_SW, 32'h1C);
    tick();
    check_ctrl("sw_ctrl", 5'b00000, 10'b0101000100, 3'b001, 1'b0);
    apply_stimulus(1'b1, I_BEQ, 32'h20);
    tick();
    check_ctrl("beq_ctrl", 5'b00000, 10'b0110001110, 3'b010, 1'b0);
    apply_stimulus(1'b1, I_JAL, 32'h24);
    tick();
    check_ctrl("jal_ctrl", 5'b00000, 10'b1000001101, 3'b011, 1'b0);
    check_output("jal_pc", 64'(ifa.out_pc), 64'h24);
    apply_stimulus(1'b1, I_LUI, 32'h28);
    tick();
    check_ctrl("lui_ctrl", 5'b00000, 10'b1000000000, 3'b100, 1'b0);
    apply_stimulus(1'b1, I_ILL, 32'h2C);
    tick();
    check_output("ill_valid", 64'(ifa.out_valid), 64'd1);
    check_ctrl("ill_ctrl", 5'b0, 10'b0, 3'b0, 1'b1);
    apply_stimulus(1'b1, I_MUL, 32'h30);
    tick();
`ifdef CTRL_MEXT_EN
    check_ctrl("mul_ctrl", 5'b10000, 10'b1110000000, 3'b000, 1'b0);
`else
    check_ctrl("mul_ctrl", 5'b00000, 10'b0, 3'b000, 1'b1);
`endif

    apply_stimulus(1'b0, I_ADD, 32'h0);
    tick();
    check_output("drain_valid", 64'(ifa.out_valid), 64'd0);

    ifa.out_ready = 1'b0;
    apply_stimulus(1'b1, I_ADD, 32'h100);
    tick();
    check_output("bp_valid", 64'(ifa.out_valid), 64'd1);
    apply_stimulus(1'b1, I_SUB, 32'h104);
    check_output("bp_in_ready", 64'(ifa.in_ready), 64'd0);
    tick();
    check_output("bp_hold_pc", 64'(ifa.out_pc), 64'h100);
    check_ctrl("bp_hold_ctrl", 5'b00000, 10'b1110000000, 3'b000, 1'b0);
    ifa.out_ready = 1'b1;
    apply_stimulus(1'b0, I_SUB, 32'h104);
    tick();
    check_output("bp_drain_valid", 64'(ifa.out_valid), 64'd0);

    apply_stimulus(1'b1, I_ADD, 32'h200);
    tick();
    ifa.stall = 1'b1;
    apply_stimulus(1'b1, I_SUB, 32'h204);
    check_output("stall_in_ready", 64'(ifa.in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_output("stall_valid", 64'(ifa.out_valid), 64'd1);
      check_output("stall_pc", 64'(ifa.out_pc), 64'h200);
      check_ctrl("stall_ctrl", 5'b00000, 10'b1110000000, 3'b000, 1'b0);
    end
    ifa.flush = 1'b1;
    #1;
    check_output("flush_in_ready", 64'(ifa.in_ready), 64'd1);
    tick();
    check_output("flush_valid", 64'(ifa.out_valid), 64'd0);
    check_ctrl("flush_ctrl", 5'b0, 10'b0, 3'b0, 1'b0);
    ifa.flush = 1'b0;
    ifa.stall = 1'b0;

    apply_stimulus(1'b1, I_LW5, 32'h300);
    tick();
    ifa.stall = 1'b1;
    apply_stimulus(1'b1, I_USE1, 32'h304);
    tick();
    check_output("sh_valid", 64'(ifa.out_valid), 64'd1);
    check_output("sh_dm_re", 64'(ifa.out_dm_re), 64'd1);
    check_output("sh_cnt", 64'(bubble_cnt), 64'd1);
    ifa.stall = 1'b0;
    tick();
    check_output("sh_bub_valid", 64'(ifa.out_valid), 64'd0);
    check_output("sh_cnt2", 64'(bubble_cnt), 64'd2);
    check_output("sat_cnt2", 64'(sat_cnt), 64'd2);
    tick();
    check_output("sh_use_rd", 64'(ifa.out_rd), 64'd6);

    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1'b1, I_LW5, 32'h400);
      tick();
      apply_stimulus(1'b1, I_USE2, 32'h404);
      tick();
      check_output("rs2_bub_valid", 64'(ifa.out_valid), 64'd0);
      tick();
      check_output("rs2_use_rs2", 64'(ifa.out_rs2), 64'd5);
    end
    check_output("cnt_total", 64'(bubble_cnt), 64'd5);
    check_output("sat_cnt", 64'(sat_cnt), 64'd3);

    apply_stimulus(1'b1, I_ADD, 32'h500);
    tick();
    check_output("pre_rst_valid", 64'(ifa.out_valid), 64'd1);
    #3 rst_n = 1'b0;
    #1;
    check_output("mrst_valid", 64'(ifa.out_valid), 64'd0);
    check_ctrl("mrst_ctrl", 5'b0, 10'b0, 3'b0, 1'b0);
    check_output("mrst_rd", 64'(ifa.out_rd), 64'd0);
    check_output("mrst_rs1", 64'(ifa.out_rs1), 64'd0);
    check_output("mrst_pc", 64'(ifa.out_pc), 64'd0);
    check_output("mrst_cnt", 64'(bubble_cnt), 64'd0);
    check_output("mrst_sat", 64'(sat_cnt), 64'd0);
    check_output("mrst_in_ready", 64'(ifa.in_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
